// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: FSM encoding, frame geometry
// and default protocol bytes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESP,
    S_RESP_WAIT
  } state_t;

  localparam int FRAME_LEN = 7;
  // Index of the checksum byte once the sync byte has been stripped off
  localparam logic [2:0] CHK_IDX = 3'(FRAME_LEN - 2);

  localparam logic [7:0] DEF_SYNC = 8'hA5;
  localparam logic [7:0] DEF_ACK  = 8'h06;
  localparam logic [7:0] DEF_NAK  = 8'h15;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Response launcher: waits for an idle transmitter, fires a single registered
// tx_start, then waits for the byte to finish before releasing the sequencer.
module uart_resp_tx (
  input  logic clk,
  input  logic rst,
  input  logic in_resp,
  input  logic in_resp_wait,
  input  logic tx_busy,
  output logic tx_start,
  output logic launch,
  output logic finish
);

  always_comb begin
    launch = in_resp && !tx_busy;
    finish = in_resp_wait && !tx_busy;
  end

  // Reset has priority so a launch pending in the reset cycle never reaches the UART
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
    end else begin
      tx_start <= launch;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses sync/op/addr/len/chk frames from a UART receiver, issues one command at a
// time to a flash engine, and answers with an ACK or NAK byte.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC,
  parameter logic [7:0] ACK_BYTE  = DEF_ACK,
  parameter logic [7:0] NAK_BYTE  = DEF_NAK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_endofpacket,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_len,
  input  logic        done,
  input  logic        done_ok,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  state_t      state;
  state_t      state_next;
  logic [2:0]  idx;
  logic [7:0]  acc;
  logic [7:0]  chk;
  logic        sync_seen;
  logic        rx_take;
  logic        frame_last;
  logic        abort;
  logic        chk_ok;
  logic        overrun;
  logic        err_event;
  logic        resp_launch;
  logic        resp_finish;

  assign sync_seen  = (state == S_IDLE) && rx_data_ready && (rx_data == SYNC_BYTE);
  assign rx_take    = (state == S_COLLECT) && rx_data_ready;
  assign frame_last = rx_take && (idx == CHK_IDX);
  // A byte arriving with the line gap is consumed first; only a still-incomplete frame aborts
  assign abort      = (state == S_COLLECT) && rx_endofpacket && !frame_last;
  assign chk_ok     = (acc == chk);
  assign overrun    = rx_data_ready && (state != S_IDLE) && (state != S_COLLECT);
  assign err_event  = abort || ((state == S_CHECK) && !chk_ok) || overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (sync_seen) state_next = S_COLLECT;
      S_COLLECT: begin
        if (frame_last) begin
          state_next = S_CHECK;
        end else if (abort) begin
          state_next = S_IDLE;
        end
      end
      S_CHECK:     state_next = chk_ok ? S_ISSUE : S_RESP;
      S_ISSUE:     if (cmd_ready) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (done) state_next = S_RESP;
      S_RESP:      if (resp_launch) state_next = S_RESP_WAIT;
      S_RESP_WAIT: if (resp_finish) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    cmd_valid = (state == S_ISSUE);
  end

  // Frame fields double as the command outputs; they only change while collecting
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 3'd0;
      acc      <= 8'h00;
      chk      <= 8'h00;
      cmd_op   <= 8'h00;
      cmd_addr <= 24'h000000;
      cmd_len  <= 8'h00;
      tx_data  <= 8'h00;
      err_cnt  <= 8'h00;
    end else begin
      if (sync_seen) begin
        idx <= 3'd0;
        acc <= 8'h00;
      end
      if (rx_take) begin
        case (idx)
          3'd0:    cmd_op          <= rx_data;
          3'd1:    cmd_addr[23:16] <= rx_data;
          3'd2:    cmd_addr[15:8]  <= rx_data;
          3'd3:    cmd_addr[7:0]   <= rx_data;
          3'd4:    cmd_len         <= rx_data;
          default: chk             <= rx_data;
        endcase
        if (idx != CHK_IDX) begin
          acc <= acc ^ rx_data;
          idx <= idx + 3'd1;
        end
      end
      if ((state == S_CHECK) && !chk_ok) begin
        tx_data <= NAK_BYTE;
      end
      if ((state == S_WAIT_DONE) && done) begin
        tx_data <= done_ok ? ACK_BYTE : NAK_BYTE;
      end
      if (err_event) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  uart_resp_tx u_resp_tx (
    .clk          (clk),
    .rst          (rst),
    .in_resp      (state == S_RESP),
    .in_resp_wait (state == S_RESP_WAIT),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .launch       (resp_launch),
    .finish       (resp_finish)
  );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: expected commands and response bytes are
// queued as frames are driven and checked when the DUT hands them out.
module tb_uart_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_data_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_endofpacket = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        done = 1'b0;
  logic        done_ok = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  logic        hold_busy = 1'b0;
  int          tx_cnt = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [7:0]  exp_tx[$];
  cmd_t        sb_cmd;
  logic [7:0]  sb_tx;
  int          checks = 0;
  int          passes = 0;
  int          cmd_hs_cnt = 0;
  int          tx_pulse_cnt = 0;

  uart_cmd_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_ready  (rx_data_ready),
    .rx_data        (rx_data),
    .rx_endofpacket (rx_endofpacket),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_busy        (tx_busy),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .done           (done),
    .done_ok        (done_ok),
    .busy           (busy),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises with tx_start and stays up a few cycles afterwards
  assign tx_busy = tx_start || (tx_cnt != 0) || hold_busy;
  always @(posedge clk) begin
    if (tx_start) tx_cnt <= 4;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      cmd_hs_cnt++;
      checks++;
      if (exp_cmd.size() == 0) begin
        $display("[TB] FAIL sb_cmd: unexpected command op=%h addr=%h len=%h, none expected",
                 cmd_op, cmd_addr, cmd_len);
      end else begin
        sb_cmd = exp_cmd.pop_front();
        if ({cmd_op, cmd_addr, cmd_len} !== sb_cmd)
          $display("[TB] FAIL sb_cmd: got %h/%h/%h expected %h/%h/%h", cmd_op, cmd_addr,
                   cmd_len, sb_cmd.op, sb_cmd.addr, sb_cmd.len);
        else passes++;
      end
    end
    if (tx_start) begin
      tx_pulse_cnt++;
      checks++;
      if (exp_tx.size() == 0) begin
        $display("[TB] FAIL sb_tx: unexpected tx_start with tx_data=%h", tx_data);
      end else begin
        sb_tx = exp_tx.pop_front();
        if (tx_data !== sb_tx) $display("[TB] FAIL sb_tx: got %h expected %h", tx_data, sb_tx);
        else passes++;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [23:0] addr,
                                            input logic [7:0] len);
    return op ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ len;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rx_data_ready = 1'b0;
    rx_endofpacket = 1'b0;
    done = 1'b0;
    cmd_ready = 1'b1;
    hold_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1 rx_data_ready = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] op, input logic [23:0] addr, input logic [7:0] len);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(len);
  endtask

  task automatic pulse_done(input logic ok);
    done = 1'b1;
    done_ok = ok;
    @(posedge clk);
    #1 done = 1'b0;
  endtask

  // Leaves the caller one cycle after the handshake, i.e. in WAIT_DONE
  task automatic wait_handshake(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && tx_busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_start, cmd_valid, busy} !== 3'b000)
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {tx_start, cmd_valid, busy});
    else passes++;
    checks++;
    if ({err_cnt, tx_data} !== 16'h0000)
      $display("[TB] FAIL reset_regs: err_cnt=%h tx_data=%h expected 00/00", err_cnt, tx_data);
    else passes++;
    checks++;
    if ({cmd_op, cmd_addr, cmd_len} !== 40'h0)
      $display("[TB] FAIL reset_cmd: got %h expected 0", {cmd_op, cmd_addr, cmd_len});
    else passes++;
    #1 rst = 1'b0;
  endtask

  task automatic test_good_frame();
    bit ok;
    do_reset();
    exp_cmd.push_back('{8'h03, 24'h123456, 8'h10});
    send_head(8'h03, 24'h123456, 8'h10);
    send_byte(8'h63);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0) $display("[TB] FAIL good_latency_n1: cmd_valid=%b expected 0", cmd_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1) $display("[TB] FAIL good_latency_n2: cmd_valid=%b expected 1", cmd_valid);
    else passes++;
    @(posedge clk);
    #1;
    exp_tx.push_back(8'h06);
    pulse_done(1'b1);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) $display("[TB] FAIL good_tx_m1: tx_start=%b expected 0", tx_start);
    else passes++;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) $display("[TB] FAIL good_tx_m2: tx_start=%b expected 1", tx_start);
    else passes++;
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || err_cnt !== 8'h00)
      $display("[TB] FAIL good_idle: idle=%b err_cnt=%h expected 1/00", ok, err_cnt);
    else passes++;
  endtask

  task automatic test_bad_chk();
    bit ok;
    int hs0;
    do_reset();
    hs0 = cmd_hs_cnt;
    exp_tx.push_back(8'h15);
    send_head(8'h03, 24'h123456, 8'h10);
    send_byte(8'h64);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || cmd_hs_cnt != hs0)
      $display("[TB] FAIL badchk_nocmd: idle=%b cmds=%0d expected 1/0", ok, cmd_hs_cnt - hs0);
    else passes++;
    checks++;
    if (tx_data !== 8'h15 || err_cnt !== 8'h01)
      $display("[TB] FAIL badchk_resp: tx_data=%h err_cnt=%h expected 15/01", tx_data, err_cnt);
    else passes++;
  endtask

  task automatic test_abort();
    bit ok;
    int tx0;
    do_reset();
    tx0 = tx_pulse_cnt;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h12);
    rx_endofpacket = 1'b1;
    @(posedge clk);
    #1 rx_endofpacket = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_cnt !== 8'h01 || tx_pulse_cnt != tx0)
      $display("[TB] FAIL abort_state: busy=%b err_cnt=%h tx_pulses=%0d expected 0/01/0",
               busy, err_cnt, tx_pulse_cnt - tx0);
    else passes++;
    exp_cmd.push_back('{8'h42, 24'h00A0B0, 8'h08});
    send_head(8'h42, 24'h00A0B0, 8'h08);
    send_byte(frame_chk(8'h42, 24'h00A0B0, 8'h08));
    wait_handshake(ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL abort_next_cmd: handshake=%b expected 1", ok);
    else passes++;
    exp_tx.push_back(8'h06);
    pulse_done(1'b1);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || err_cnt !== 8'h01)
      $display("[TB] FAIL abort_next_resp: idle=%b err_cnt=%h expected 1/01", ok, err_cnt);
    else passes++;
  endtask

  task automatic test_eop_with_chk();
    bit ok;
    do_reset();
    exp_cmd.push_back('{8'h7E, 24'hFEDCBA, 8'hFF});
    send_head(8'h7E, 24'hFEDCBA, 8'hFF);
    rx_endofpacket = 1'b1;
    send_byte(frame_chk(8'h7E, 24'hFEDCBA, 8'hFF));
    rx_endofpacket = 1'b0;
    wait_handshake(ok);
    checks++;
    if (ok !== 1'b1 || err_cnt !== 8'h00)
      $display("[TB] FAIL eopchk_cmd: handshake=%b err_cnt=%h expected 1/00", ok, err_cnt);
    else passes++;
    exp_tx.push_back(8'h15);
    pulse_done(1'b0);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL eopchk_idle: idle=%b expected 1", ok);
    else passes++;
  endtask

  task automatic test_stall();
    bit ok;
    int stable;
    cmd_t want;
    do_reset();
    cmd_ready = 1'b0;
    want = '{8'h20, 24'hABCDEF, 8'h04};
    exp_cmd.push_back(want);
    send_head(want.op, want.addr, want.len);
    send_byte(frame_chk(want.op, want.addr, want.len));
    for (int i = 0; i < 10 && cmd_valid !== 1'b1; i++) @(negedge clk);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1 && {cmd_op, cmd_addr, cmd_len} === want) stable++;
      rx_data = 8'hA5;
      rx_data_ready = (i == 5);
    end
    rx_data_ready = 1'b0;
    checks++;
    if (stable != 20) $display("[TB] FAIL stall_stable: %0d stable cycles expected 20", stable);
    else passes++;
    checks++;
    if (err_cnt !== 8'h01) $display("[TB] FAIL stall_overrun: err_cnt=%h expected 01", err_cnt);
    else passes++;
    cmd_ready = 1'b1;
    wait_handshake(ok);
    exp_tx.push_back(8'h15);
    pulse_done(1'b0);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || tx_data !== 8'h15)
      $display("[TB] FAIL stall_resp: idle=%b tx_data=%h expected 1/15", ok, tx_data);
    else passes++;
  endtask

  task automatic test_tx_busy_hold();
    bit ok;
    int quiet;
    int tx0;
    do_reset();
    exp_cmd.push_back('{8'h01, 24'h000010, 8'h20});
    send_head(8'h01, 24'h000010, 8'h20);
    send_byte(frame_chk(8'h01, 24'h000010, 8'h20));
    wait_handshake(ok);
    hold_busy = 1'b1;
    exp_tx.push_back(8'h06);
    tx0 = tx_pulse_cnt;
    pulse_done(1'b1);
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start === 1'b0 && busy === 1'b1 && tx_data === 8'h06) quiet++;
    end
    checks++;
    if (quiet != 50) $display("[TB] FAIL hold_quiet: %0d quiet cycles expected 50", quiet);
    else passes++;
    hold_busy = 1'b0;
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1 || tx_pulse_cnt - tx0 != 1)
      $display("[TB] FAIL hold_pulse: idle=%b pulses=%0d expected 1/1", ok, tx_pulse_cnt - tx0);
    else passes++;
  endtask

  task automatic test_multi_error();
    bit ok;
    do_reset();
    exp_tx.push_back(8'h15);
    send_head(8'h55, 24'h010203, 8'h09);
    rx_data = 8'h00;
    rx_data_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rx_data_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'h01) $display("[TB] FAIL multi_err: err_cnt=%h expected 01", err_cnt);
    else passes++;
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL multi_idle: idle=%b expected 1", ok);
    else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5);
      rx_endofpacket = 1'b1;
      @(posedge clk);
      #1 rx_endofpacket = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'hFF || busy !== 1'b0)
      $display("[TB] FAIL sat_err: err_cnt=%h busy=%b expected FF/0", err_cnt, busy);
    else passes++;
  endtask

  task automatic test_reset_wait_done();
    bit ok;
    int tx0;
    do_reset();
    exp_cmd.push_back('{8'h09, 24'h777777, 8'h01});
    send_head(8'h09, 24'h777777, 8'h01);
    send_byte(frame_chk(8'h09, 24'h777777, 8'h01));
    wait_handshake(ok);
    tx0 = tx_pulse_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_start, cmd_valid, busy} !== 3'b000 || err_cnt !== 8'h00 || tx_data !== 8'h00 ||
        {cmd_op, cmd_addr, cmd_len} !== 40'h0)
      $display("[TB] FAIL rstwd_outputs: ctrl=%b err=%h tx=%h cmd=%h expected all zero",
               {tx_start, cmd_valid, busy}, err_cnt, tx_data, {cmd_op, cmd_addr, cmd_len});
    else passes++;
    pulse_done(1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'h00 || tx_pulse_cnt != tx0)
      $display("[TB] FAIL rstwd_done_ignored: busy=%b tx_data=%h pulses=%0d expected 0/00/0",
               busy, tx_data, tx_pulse_cnt - tx0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_abort();
    test_eop_with_chk();
    test_stall();
    test_tx_busy_hold();
    test_multi_error();
    test_saturation();
    test_reset_wait_done();
    checks++;
    if (exp_cmd.size() != 0 || exp_tx.size() != 0)
      $display("[TB] FAIL sb_drained: %0d commands and %0d responses never seen, expected 0/0",
               exp_cmd.size(), exp_tx.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, success response.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, failure response.
REQ-004 SHALL have port clk, input, 1, the single clock; the block SHALL use one clock, reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_data_ready, input, 1, one-cycle strobe from the UART receiver marking a valid rx_data.
REQ-007 SHALL have port rx_data, input, 8, received byte.
REQ-008 SHALL have port rx_endofpacket, input, 1, one-cycle strobe marking a line gap.
REQ-009 SHALL have port tx_start, output, 1, one-cycle launch strobe to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8, response byte.
REQ-011 SHALL have port tx_busy, input, 1, transmitter busy; it goes high combinationally with tx_start and stays high until the byte has been sent.
REQ-012 SHALL have port cmd_valid, output, 1, command offered to the flash engine.
REQ-013 SHALL have port cmd_ready, input, 1, engine accepts the command.
REQ-014 SHALL have ports cmd_op (output, 8), cmd_addr (output, 24) and cmd_len (output, 8), carrying the command fields.
REQ-015 SHALL have port done, input, 1, one-cycle engine completion strobe.
REQ-016 SHALL have port done_ok, input, 1, completion status, qualified by done.
REQ-017 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-018 SHALL have port err_cnt, output, 8, saturating count of frame errors.

Function
REQ-019 Frame format SHALL be 7 bytes: SYNC_BYTE, op, addr[23:16], addr[15:8], addr[7:0], len, chk; chk is the XOR of op through len.
REQ-020 FSM states SHALL be IDLE, COLLECT, CHECK, ISSUE, WAIT_DONE, RESP, RESP_WAIT.
REQ-021 IDLE: on rx_data_ready with rx_data==SYNC_BYTE, go to COLLECT with byte index 0 and XOR accumulator 0; all other bytes are discarded silently.
REQ-022 COLLECT: each rx_data_ready stores the byte into the field selected by the index (0..4) and XORs it into the accumulator; the sixth byte (index 5) is chk, after which the FSM goes to CHECK.
REQ-023 COLLECT: rx_endofpacket before chk SHALL abort to IDLE, increment err_cnt and send no response.
REQ-024 If rx_endofpacket and rx_data_ready occur in the same cycle, the byte SHALL be consumed first and the abort then SHALL apply only if the frame is still incomplete.
REQ-025 CHECK (one cycle): accumulator==chk goes to ISSUE; a mismatch loads tx_data=NAK_BYTE, increments err_cnt and goes to RESP.
REQ-026 ISSUE: cmd_valid=1 with cmd_op, cmd_addr and cmd_len held stable; on cmd_valid&&cmd_ready, deassert cmd_valid on the next cycle and go to WAIT_DONE.
REQ-027 WAIT_DONE: on done, load tx_data=done_ok?ACK_BYTE:NAK_BYTE and go to RESP; done in any other state SHALL be ignored.
REQ-028 RESP: when tx_busy==0, register tx_start=1 for exactly one cycle and go to RESP_WAIT.
REQ-029 RESP_WAIT: when tx_busy==0, go to IDLE; tx_data SHALL stay stable from RESP entry until IDLE.
REQ-030 rx_data_ready in CHECK through RESP_WAIT SHALL be dropped and SHALL increment err_cnt (overrun).
REQ-031 err_cnt SHALL saturate at 8'hFF; if several error events occur in one cycle, it SHALL increment by 1 only.
REQ-032 Latency: chk received at cycle N gives cmd_valid at N+2; done at cycle M with tx_busy low gives tx_start at M+2.
REQ-033 The block SHALL accept at most one command in flight; there is no command queueing.

Reset
REQ-034 rst SHALL force IDLE, tx_start=0, cmd_valid=0, busy=0, err_cnt=0, tx_data=0, cmd_op/cmd_addr/cmd_len=0, byte index=0 and accumulator=0.
REQ-035 rst asserted mid-frame or mid-response SHALL take effect on the next edge, discard the frame and suppress any pending tx_start.

Structure
REQ-036 Package uart_cmd_pkg SHALL hold the state encoding, frame length (7) and default SYNC/ACK/NAK constants.
REQ-037 Sub-module uart_resp_tx SHALL implement the RESP/RESP_WAIT tx_start/tx_busy handshake; frame parsing SHALL stay in the top module.

Verification
REQ-038 Stimulus: bytes A5 03 12 34 56 10 63. Required: cmd_valid with op=03, addr=123456, len=10; then done with done_ok=1 -> one tx_start with tx_data=06.
REQ-039 Stimulus: the same frame with chk=64. Required: no cmd_valid; tx_data=15; err_cnt=1.
REQ-040 Stimulus: A5 03 12 followed by rx_endofpacket. Required: IDLE, no tx_start, err_cnt=1; a following valid frame is accepted.
REQ-041 Stimulus: cmd_ready held low for 20 cycles with an rx byte injected. Required: cmd_valid and fields stable for all 20 cycles; err_cnt increments for the injected byte.
REQ-042 Stimulus: tx_busy held high for 50 cycles in RESP. Required: tx_start stays 0 until tx_busy falls, then pulses exactly once.
REQ-043 Stimulus: rst in WAIT_DONE, then done. Required: all outputs at their reset values, and the done is ignored.
